// File: rtl/calc_pkg.sv
// Definitions shared between the calculator core and the seven-segment display path.
package calc_pkg;

   typedef enum logic [1:0] {
      ERRO    = 2'd0,
      PRONTA  = 2'd1,
      OCUPADA = 2'd2
   } status_t;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

endpackage

// File: rtl/display_driver_if.sv
// Calculator-to-display bundle: status and digit writes in, panel drive out.
interface display_driver_if;

   logic [1:0] status;
   logic [3:0] pos;
   logic [3:0] dig;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output status, pos, dig,
      input  an, seg, dp
   );

   modport slave (
      input  status, pos, dig,
      output an, seg, dp
   );

endinterface

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment pattern; codes 10..15 render blank.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_driver.sv
// Multiplexed 8-digit seven-segment driver: digit buffer, scan prescaler,
// leading-zero blanking and status override, with registered panel outputs.
module display_driver
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int NUM_DIG  = 8
) (
   input  logic             clock,
   input  logic             reset,
   display_driver_if.slave  bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] presc_p0;
   logic [2:0]       idx_p0;
   logic [3:0]       digit_buf [NUM_DIG];
   logic             wrap;
   logic             clear;
   logic             capture;

   logic [3:0]       digit_cur;
   logic [6:0]       dec_seg;
   logic             nz_above;
   logic [6:0]       seg_next;
   logic [7:0]       an_next;

   logic [7:0]       an_p1;
   logic [6:0]       seg_p1;

   assign wrap    = (presc_p0 == CNT_W'(SCAN_DIV - 1));
   assign clear   = (bus.status != PRONTA) && (bus.status != OCUPADA);
   assign capture = (bus.status == PRONTA) && (bus.pos < 4'(NUM_DIG));

   // ---- stage p0: scan counter and digit buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_p0 <= '0;
         idx_p0   <= '0;
      end else begin
         presc_p0 <= wrap ? '0 : presc_p0 + 1'b1;
         if (wrap)
            idx_p0 <= idx_p0 + 3'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_DIG; i++)
            digit_buf[i] <= 4'd0;
      end else if (capture) begin
         digit_buf[bus.pos[2:0]] <= bus.dig;
      end
   end

   assign digit_cur = digit_buf[idx_p0];

   seg7_decoder u_dec (
      .bcd (digit_cur),
      .seg (dec_seg)
   );

   // Any non-zero digit more significant than the one being scanned keeps zeros lit
   always_comb begin
      nz_above = 1'b0;
      for (int j = 0; j < NUM_DIG; j++)
         if (j > int'(idx_p0) && digit_buf[j] != 4'd0)
            nz_above = 1'b1;
   end

   always_comb begin
      an_next  = ~(8'b1 << idx_p0);
      seg_next = SEG_BLANK;
      case (bus.status)
         PRONTA: begin
            if (idx_p0 != 3'd0 && digit_cur == 4'd0 && !nz_above)
               seg_next = SEG_BLANK;
            else
               seg_next = dec_seg;
         end
         OCUPADA: seg_next = SEG_DASH;
         default: seg_next = (idx_p0 == 3'd0) ? SEG_E : SEG_BLANK;
      endcase
   end

   // ---- stage p1: registered panel drive
   always_ff @(posedge clock) begin
      if (reset) begin
         an_p1  <= 8'hFF;
         seg_p1 <= SEG_BLANK;
      end else begin
         an_p1  <= an_next;
         seg_p1 <= seg_next;
      end
   end

   assign bus.an  = an_p1;
   assign bus.seg = seg_p1;
   assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_display_driver.sv
// Directed bench for display_driver with a 4-cycle scan divider.
module tb_display_driver;
   import calc_pkg::*;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   display_driver_if bus();

   display_driver #(.SCAN_DIV(4), .NUM_DIG(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Lands on the first output cycle of digit d (leaves the current window first).
   task automatic wait_digit(input int d, input string tag);
      logic [7:0] target;
      int k;
      target = ~(8'b1 << d);
      k = 0;
      while (bus.an === target && k < 64) begin step(); k++; end
      k = 0;
      while (bus.an !== target && k < 64) begin step(); k++; end
      chk({tag, "_an"}, bus.an, target);
   endtask

   task automatic write_dig(input logic [3:0] p, input logic [3:0] d);
      bus.pos = p;
      bus.dig = d;
      step();
      bus.pos = 4'd9;
      bus.dig = 4'd5;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.status = PRONTA;
      bus.pos = 4'd0;
      bus.dig = 4'd0;
      step(3);
      chk("rst_an", bus.an, 8'hFF);
      chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
      chk("rst_dp", {7'b0, bus.dp}, 8'h01);

      // Scan timing straight after reset release
      reset = 1'b0;
      step();
      chk("first_an", bus.an, 8'hFE);
      chk("first_seg", {1'b0, bus.seg}, 8'h40);
      step(3);
      chk("d0_hold_an", bus.an, 8'hFE);
      step();
      chk("d1_an", bus.an, 8'hFD);
      chk("d1_blank", {1'b0, bus.seg}, 8'h7F);
      step(4);
      chk("d2_an", bus.an, 8'hFB);
      wait_digit(7, "d7");
      chk("d7_blank", {1'b0, bus.seg}, 8'h7F);

      // "47"
      write_dig(4'd0, 4'd7);
      write_dig(4'd1, 4'd4);
      wait_digit(0, "s47_0");
      chk("s47_d0", {1'b0, bus.seg}, 8'h78);
      wait_digit(1, "s47_1");
      chk("s47_d1", {1'b0, bus.seg}, 8'h19);
      wait_digit(2, "s47_2");
      chk("s47_d2", {1'b0, bus.seg}, 8'h7F);
      wait_digit(7, "s47_7");
      chk("s47_d7", {1'b0, bus.seg}, 8'h7F);

      // Write to the digit currently shown: old value first, new one next cycle
      wait_digit(0, "same_0");
      bus.pos = 4'd0;
      bus.dig = 4'd3;
      step();
      bus.pos = 4'd9;
      bus.dig = 4'd5;
      chk("same_old", {1'b0, bus.seg}, 8'h78);
      step();
      chk("same_new", {1'b0, bus.seg}, 8'h30);
      write_dig(4'd0, 4'd7);
      wait_digit(0, "pos9_0");
      chk("pos9_d0", {1'b0, bus.seg}, 8'h78);

      // 102 with an inner zero
      write_dig(4'd2, 4'd1);
      write_dig(4'd1, 4'd0);
      write_dig(4'd0, 4'd2);
      wait_digit(0, "v102_0");
      chk("v102_d0", {1'b0, bus.seg}, 8'h24);
      wait_digit(1, "v102_1");
      chk("v102_d1", {1'b0, bus.seg}, 8'h40);
      wait_digit(2, "v102_2");
      chk("v102_d2", {1'b0, bus.seg}, 8'h79);
      wait_digit(3, "v102_3");
      chk("v102_d3", {1'b0, bus.seg}, 8'h7F);

      // One cycle of ERRO clears the buffer
      bus.status = ERRO;
      step();
      bus.status = PRONTA;
      wait_digit(1, "clr_1");
      chk("clr_d1", {1'b0, bus.seg}, 8'h7F);
      wait_digit(2, "clr_2");
      chk("clr_d2", {1'b0, bus.seg}, 8'h7F);
      wait_digit(0, "clr_0");
      chk("clr_d0", {1'b0, bus.seg}, 8'h40);

      // Status change shows on the very next edge
      bus.status = ERRO;
      step();
      chk("err_now_an", bus.an, 8'hFE);
      chk("err_now_seg", {1'b0, bus.seg}, 8'h06);
      bus.status = 2'd3;
      wait_digit(3, "rsv_3");
      chk("rsv_d3", {1'b0, bus.seg}, 8'h7F);
      wait_digit(0, "rsv_0");
      chk("rsv_d0", {1'b0, bus.seg}, 8'h06);
      bus.status = PRONTA;
      step();
      chk("err_back", {1'b0, bus.seg}, 8'h40);

      // OCUPADA holds the buffer and shows dashes
      write_dig(4'd0, 4'd7);
      write_dig(4'd1, 4'd4);
      bus.status = OCUPADA;
      bus.pos = 4'd2;
      bus.dig = 4'd9;
      wait_digit(0, "busy_0");
      chk("busy_d0", {1'b0, bus.seg}, 8'h3F);
      wait_digit(1, "busy_1");
      chk("busy_d1", {1'b0, bus.seg}, 8'h3F);
      wait_digit(5, "busy_5");
      chk("busy_d5", {1'b0, bus.seg}, 8'h3F);
      bus.pos = 4'd9;
      bus.dig = 4'd5;
      bus.status = PRONTA;
      wait_digit(0, "back_0");
      chk("back_d0", {1'b0, bus.seg}, 8'h78);
      wait_digit(1, "back_1");
      chk("back_d1", {1'b0, bus.seg}, 8'h19);
      wait_digit(2, "back_2");
      chk("back_d2", {1'b0, bus.seg}, 8'h7F);

      // Reset mid-scan at digit 5
      wait_digit(5, "mid_5");
      reset = 1'b1;
      step();
      chk("mid_rst_an", bus.an, 8'hFF);
      chk("mid_rst_seg", {1'b0, bus.seg}, 8'h7F);
      reset = 1'b0;
      step();
      chk("mid_rel_an", bus.an, 8'hFE);
      chk("mid_rel_seg", {1'b0, bus.seg}, 8'h40);
      wait_digit(1, "mid_1");
      chk("mid_d1", {1'b0, bus.seg}, 8'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
